// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts up to MAX_BURST words, ends early when the owner drops valid, and stalls on FIFO full.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clkin,
   input  logic                       nrst_in,
   input  logic [NUM_REQ-1:0]         req_valid_in,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data_in,
   output logic [NUM_REQ-1:0]         req_ready_out,
   input  logic                       fifo_full_in,
   output logic                       fifo_write_out,
   output logic [WIDTH-1:0]           fifo_data_out,
   output logic [NUM_REQ-1:0]         grant_out,
   output logic                       busy_out
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        last_grant;
   logic [IW-1:0]        gidx;
   logic [IW-1:0]        pick;
   logic [NUM_REQ-1:0]   xfer;
   logic                 leave;

   // First valid requester strictly after 'last', wrapping modulo NUM_REQ.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IW-1:0]      last);
      logic [IW-1:0] p;
      logic          found;
      int            idx;
      p     = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && v[IW'(idx)]) begin
            found = 1'b1;
            p     = IW'(idx);
         end
      end
      return p;
   endfunction

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_out[i]) gidx = IW'(i);
      end
   end

   assign pick = rr_pick(req_valid_in, last_grant);

   // Reset is folded into the combinational outputs so an aborted burst never writes in its reset cycle.
   assign req_ready_out  = (busy_out && nrst_in && !fifo_full_in) ? grant_out : '0;
   assign xfer           = req_valid_in & req_ready_out;
   assign fifo_write_out = |xfer;
   assign fifo_data_out  = (busy_out && nrst_in) ? req_data_in[int'(gidx)*WIDTH +: WIDTH] : '0;

   assign leave = !req_valid_in[gidx] || (fifo_write_out && (cnt == CNT_LAST));

   always_ff @(posedge clkin) begin
      if (!nrst_in) begin
         state      <= IDLE;
         grant_out  <= '0;
         busy_out   <= 1'b0;
         cnt        <= '0;
         last_grant <= IW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid_in) begin
                  grant_out <= NUM_REQ'(1) << pick;
                  cnt       <= '0;
                  busy_out  <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (leave) begin
                  last_grant <= gidx;
                  grant_out  <= '0;
                  busy_out   <= 1'b0;
                  state      <= IDLE;
               end else if (fifo_write_out) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
